dac_frame_sched: RTL
====================

// Module: dac_frame_sched
// PURPOSE
//   Posedge sys_clk controller that drives spi_main_x2 for the DAC8411 output path.
//   - Generates the sample-rate tick and buffers one DDS sample.
//   - Starts an SPI frame per tick and serialises power-state change requests
//     into the same SPI stream.
//   - Tracks busy/done from the SPI csb line and flags underruns.
// PARAMETERS
//   WORD_WIDTH  16  sample / SPI data word width (matches spi_main_x2)
//   DIV_WIDTH   12  width of sample-rate divider; tick period = rate_div+1 cycles
// PORTS
//   sys_clk         in   1           system clock; all state on rising edge
//   rst_n           in   1           asynchronous, active-low reset
//   enable          in   1           1 = tick counter runs
//   rate_div        in   DIV_WIDTH   tick period minus one; sampled each cycle
//   sample_in       in   WORD_WIDTH  next DAC code from DDS
//   sample_valid    in   1           sample_in valid
//   sample_ready    out  1           1-deep buffer empty; transfer when valid&ready
//   pwr_req         in   1           level request to change DAC power state
//   pwr_state_in    in   2           requested power state
//   pwr_ack         out  1           1-cycle pulse when request latched
//   spi_csb         in   1           csb from spi_main_x2 (1 = idle/done)
//   spi_load        out  1           load strobe to spi_main_x2
//   spi_word        out  WORD_WIDTH  parallel_in to spi_main_x2; held during frame
//   spi_power_state out  2           power_state to spi_main_x2; held during frame
//   busy            out  1           frame in progress (state != IDLE)
//   underrun        out  1           sticky; tick with empty buffer; cleared by reset
// BEHAVIOUR
//   Reset: state IDLE; spi_load=0, pwr_ack=0, busy=0, underrun=0, sample_ready=1;
//     spi_word=0, spi_power_state=2'b00, tick counter=0, tick_pend=0.
//   Tick counter: while enable, counts 0..rate_div; tick on the cycle the count
//     equals rate_div, then it wraps to 0.
//     If rate_div decreases below the count, the counter wraps to 0 without a tick.
//     enable=0 holds the count at 0 and clears tick_pend; the buffer is kept.
//   tick_pend set by tick, cleared when a sample frame launches.
//     A tick while tick_pend=1 is lost and sets underrun.
//   FSM: IDLE -> LOAD -> ARMED -> BUSY -> IDLE.
//     IDLE: leave only when spi_csb=1. This covers a reset mid-frame, because
//       spi_main_x2 has no reset.
//       - pwr_req=1: power frame. Latch pwr_state_in into spi_power_state, pulse
//         pwr_ack, spi_word unchanged. Has priority over a sample frame; tick stays
//         pending.
//       - else tick_pend=1: sample frame. If buffer full, spi_word<=buffer and buffer
//         empties; if empty, resend last spi_word and set underrun. Clear tick_pend.
//     LOAD: spi_load=1 for exactly one cycle. The SPI core samples it at the
//       mid-cycle negedge.
//     ARMED: wait for spi_csb=0. A 4-cycle timeout returns to IDLE (frame dropped).
//     BUSY: wait for spi_csb=1, then IDLE. The next frame may launch the same cycle.
//   Buffer: a write (valid&ready) and a launch pop in the same cycle are legal.
//     sample_ready deasserts the cycle after the write.
//   spi_word and spi_power_state change only in IDLE at launch: stable for the
//     whole frame.
//   Minimum frame spacing: 18 sclk + 3 cycles. rate_div < 21 at full speed
//     guarantees underrun.
// CONFIGURATION
//   DAC_SCHED_UNDERRUN_CNT_EN defined:
//     - Adds output underrun_count [7:0]; reset 0.
//     - +1 on every underrun event (empty-buffer launch or lost tick).
//     - Saturates at 8'hFF.
//   Not defined: no underrun_count port; only the sticky underrun flag.
// TESTING
//   1. rate_div=63, sample each tick, SPI full speed:
//      -> one spi_load every 64 cycles, spi_word matches input order, underrun=0.
//   2. No sample_valid after 0x1234 sent:
//      -> next tick resends 0x1234, underrun=1 (count=1 when _EN).
//   3. pwr_req=1 with state 2'b11 on the same cycle as a pending tick:
//      -> power frame first with pwr_ack pulse, then sample frame; words/state
//         unchanged mid-frame.
//   4. rst_n low mid-frame, released with spi_csb=0:
//      -> outputs at reset values, no spi_load until spi_csb=1.
//   5. rate_div=10 (< frame time):
//      -> ticks lost, underrun set; counter saturates at 8'hFF over 300 ticks (_EN).
//   6. spi_csb tied high:
//      -> ARMED times out after 4 cycles, returns to IDLE, no lockup.

Source files
------------

// File: rtl/dac_frame_sched.sv
// Frame scheduler for the DAC8411 path: sample-rate tick, 1-deep sample buffer, SPI frame
// sequencing for spi_main_x2. Define DAC_SCHED_UNDERRUN_CNT_EN to add underrun_count.
module dac_frame_sched #(
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned DIV_WIDTH  = 12
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [DIV_WIDTH-1:0]  rate_div,
   input  logic [WORD_WIDTH-1:0] sample_in,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   input  logic                  pwr_req,
   input  logic [1:0]            pwr_state_in,
   output logic                  pwr_ack,
   input  logic                  spi_csb,
   output logic                  spi_load,
   output logic [WORD_WIDTH-1:0] spi_word,
   output logic [1:0]            spi_power_state,
   output logic                  busy,
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
   output logic                  underrun,
   output logic [7:0]            underrun_count
`else
   output logic                  underrun
`endif
);

   typedef enum logic [1:0] {StIdle, StLoad, StArmed, StBusy} state_e;

   state_e                state_q, state_d;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  tick_pend_q, tick_pend_d;
   logic [WORD_WIDTH-1:0] buf_q, buf_d;
   logic                  buf_full_q, buf_full_d;
   logic [WORD_WIDTH-1:0] word_q, word_d;
   logic [1:0]            pstate_q, pstate_d;
   logic                  pwr_ack_q, pwr_ack_d;
   logic                  underrun_q, underrun_d;
   logic [2:0]            tmo_q, tmo_d;

   logic tick;
   logic launch_pwr;
   logic launch_smp;
   logic buf_wr;
   logic buf_pop;
   logic tick_lost;
   logic empty_launch;

   // Sample-rate counter; a shrinking rate_div below the count wraps without a tick.
   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q;
      if (!enable) begin
         cnt_d = '0;
      end else if (cnt_q == rate_div) begin
         tick  = 1'b1;
         cnt_d = '0;
      end else if (cnt_q > rate_div) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // spi_main_x2 has no reset, so IDLE only launches once csb shows the core idle.
   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      launch_pwr = 1'b0;
      launch_smp = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (spi_csb) begin
               if (pwr_req) begin
                  launch_pwr = 1'b1;
                  state_d    = StLoad;
               end else if (tick_pend_q) begin
                  launch_smp = 1'b1;
                  state_d    = StLoad;
               end
            end
         end
         StLoad: begin
            state_d = StArmed;
            tmo_d   = '0;
         end
         StArmed: begin
            if (!spi_csb) begin
               state_d = StBusy;
            end else if (tmo_q == 3'd3) begin
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + 3'd1;
            end
         end
         StBusy: begin
            if (spi_csb) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      buf_wr       = sample_valid && !buf_full_q;
      buf_pop      = launch_smp && buf_full_q;
      empty_launch = launch_smp && !buf_full_q;
      tick_lost    = tick && tick_pend_q && !launch_smp;

      buf_d      = buf_wr ? sample_in : buf_q;
      buf_full_d = buf_full_q;
      if (buf_pop) begin
         buf_full_d = 1'b0;
      end else if (buf_wr) begin
         buf_full_d = 1'b1;
      end

      word_d     = buf_pop ? buf_q : word_q;
      pstate_d   = launch_pwr ? pwr_state_in : pstate_q;
      pwr_ack_d  = launch_pwr;
      underrun_d = underrun_q | tick_lost | empty_launch;

      tick_pend_d = tick_pend_q;
      if (!enable) begin
         tick_pend_d = 1'b0;
      end else if (tick) begin
         tick_pend_d = 1'b1;
      end else if (launch_smp) begin
         tick_pend_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         tick_pend_q <= 1'b0;
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         word_q      <= '0;
         pstate_q    <= 2'b00;
         pwr_ack_q   <= 1'b0;
         underrun_q  <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tick_pend_q <= tick_pend_d;
         buf_q       <= buf_d;
         buf_full_q  <= buf_full_d;
         word_q      <= word_d;
         pstate_q    <= pstate_d;
         pwr_ack_q   <= pwr_ack_d;
         underrun_q  <= underrun_d;
         tmo_q       <= tmo_d;
      end
   end

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
   logic [7:0] ucnt_q, ucnt_d;

   // Lost tick and empty launch are mutually exclusive, so +1 covers every event.
   always_comb begin
      ucnt_d = ucnt_q;
      if ((tick_lost || empty_launch) && (ucnt_q != 8'hFF)) begin
         ucnt_d = ucnt_q + 8'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         ucnt_q <= '0;
      end else begin
         ucnt_q <= ucnt_d;
      end
   end

   assign underrun_count = ucnt_q;
`endif

   assign sample_ready    = !buf_full_q;
   assign pwr_ack         = pwr_ack_q;
   assign spi_load        = (state_q == StLoad);
   assign spi_word        = word_q;
   assign spi_power_state = pstate_q;
   assign busy            = (state_q != StIdle);
   assign underrun        = underrun_q;

endmodule
